// File: rtl/system_buffer_reader.sv
// Port-B consumer of the system buffer: fetches words into a 64-bit MSB-aligned
// bit accumulator and presents a 32-bit window to the bitstream parser.
module system_buffer_reader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH:0]   Write_Pointer_I,
  output logic                  Buffer_Enable_O,
  output logic [ADDR_WIDTH-1:0] Buffer_Address_O,
  input  logic [31:0]           Buffer_Data_I,
  output logic [ADDR_WIDTH:0]   Read_Pointer_O,
  output logic [31:0]           Bits_O,
  output logic                  Bits_Valid_O,
  input  logic [5:0]            Shift_I,
  input  logic                  Shift_Valid_I,
  input  logic                  Flush_I,
  output logic                  Error_O
);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t              state, state_next;
  logic [63:0]         acc, acc_shifted, acc_next;
  logic [6:0]          count, count_after_shift, count_next;
  logic                shift_ok, shift_bad, empty, fetch;

  // Shift is applied before any capture so an insert lands at the post-shift count.
  always_comb begin
    shift_ok          = Shift_Valid_I && (Shift_I <= 6'd32) && Bits_Valid_O;
    shift_bad         = Shift_Valid_I && !shift_ok;
    acc_shifted       = shift_ok ? (acc << Shift_I) : acc;
    count_after_shift = shift_ok ? (count - {1'b0, Shift_I}) : count;
    empty             = (Write_Pointer_I == Read_Pointer_O);
    fetch             = (state == IDLE) && !empty && (count_after_shift <= 7'd32) && !Flush_I;
    acc_next          = acc_shifted;
    count_next        = count_after_shift;
    if (state == CAPTURE) begin
      acc_next   = acc_shifted | ({Buffer_Data_I, 32'h0} >> count_after_shift);
      count_next = count_after_shift + 7'd32;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch) state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (Flush_I) state_next = IDLE;
  end

  always_comb begin
    Buffer_Enable_O  = fetch;
    Buffer_Address_O = Read_Pointer_O[ADDR_WIDTH-1:0];
    Bits_O           = acc[63:32];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc            <= '0;
      count          <= '0;
      Bits_Valid_O   <= 1'b0;
      Error_O        <= 1'b0;
      Read_Pointer_O <= '0;
    end else if (Flush_I) begin
      acc            <= '0;
      count          <= '0;
      Bits_Valid_O   <= 1'b0;
      Error_O        <= 1'b0;
      Read_Pointer_O <= Write_Pointer_I;
    end else begin
      acc          <= acc_next;
      count        <= count_next;
      Bits_Valid_O <= (count_next >= 7'd32);
      if (shift_bad) Error_O <= 1'b1;
      if (fetch)     Read_Pointer_O <= Read_Pointer_O + (ADDR_WIDTH+1)'(1);
    end
  end

endmodule

// File: tb/tb_system_buffer_reader.sv
// Directed bench for system_buffer_reader with a 1024 x 32 buffer model on port B.
module tb_system_buffer_reader;

  logic        clock = 1'b0;
  logic        resetn;
  logic [10:0] Write_Pointer_I;
  logic        Buffer_Enable_O;
  logic [9:0]  Buffer_Address_O;
  logic [31:0] Buffer_Data_I;
  logic [10:0] Read_Pointer_O;
  logic [31:0] Bits_O;
  logic        Bits_Valid_O;
  logic [5:0]  Shift_I;
  logic        Shift_Valid_I;
  logic        Flush_I;
  logic        Error_O;

  logic [31:0] mem [1024];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          en_cnt = 0;
  logic [9:0]  en_addr [16];
  int          en_cyc [16];

  system_buffer_reader #(.ADDR_WIDTH(10)) dut (
    .clock            (clock),
    .resetn           (resetn),
    .Write_Pointer_I  (Write_Pointer_I),
    .Buffer_Enable_O  (Buffer_Enable_O),
    .Buffer_Address_O (Buffer_Address_O),
    .Buffer_Data_I    (Buffer_Data_I),
    .Read_Pointer_O   (Read_Pointer_O),
    .Bits_O           (Bits_O),
    .Bits_Valid_O     (Bits_Valid_O),
    .Shift_I          (Shift_I),
    .Shift_Valid_I    (Shift_Valid_I),
    .Flush_I          (Flush_I),
    .Error_O          (Error_O)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (Buffer_Enable_O) Buffer_Data_I <= mem[Buffer_Address_O];
    if (resetn && Buffer_Enable_O) begin
      if (en_cnt < 16) begin
        en_addr[en_cnt] = Buffer_Address_O;
        en_cyc[en_cnt]  = cyc;
      end
      en_cnt = en_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0; Write_Pointer_I = '0; Shift_I = '0; Shift_Valid_I = 1'b0; Flush_I = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    #12;
    chk("rst_en",   64'(Buffer_Enable_O),  64'd0);
    chk("rst_addr", 64'(Buffer_Address_O), 64'd0);
    chk("rst_rp",   64'(Read_Pointer_O),   64'd0);
    chk("rst_bits", 64'(Bits_O),           64'd0);
    chk("rst_bv",   64'(Bits_Valid_O),     64'd0);
    chk("rst_err",  64'(Error_O),          64'd0);
    @(negedge clock) resetn = 1'b1;
    step(1);

    // two words available -> back-to-back fetches two cycles apart
    mem[0] = 32'hDEADBEEF; mem[1] = 32'h01234567; Write_Pointer_I = 11'd2;
    step(6);
    chk("fill_en_cnt", 64'(en_cnt), 64'd2);
    chk("fill_addr0",  64'(en_addr[0]), 64'd0);
    chk("fill_addr1",  64'(en_addr[1]), 64'd1);
    chk("fill_gap",    64'(en_cyc[1] - en_cyc[0]), 64'd2);
    chk("fill_bits",   64'(Bits_O), 64'hDEADBEEF);
    chk("fill_bv",     64'(Bits_Valid_O), 64'd1);
    chk("fill_rp",     64'(Read_Pointer_O), 64'd2);

    Shift_Valid_I = 1'b1; Shift_I = 6'd8; step(1); Shift_Valid_I = 1'b0;
    chk("sh8_bits", 64'(Bits_O), 64'hADBEEF01);
    chk("sh8_bv",   64'(Bits_Valid_O), 64'd1);
    Shift_Valid_I = 1'b1; Shift_I = 6'd24; step(1); Shift_Valid_I = 1'b0;
    chk("sh24_bits", 64'(Bits_O), 64'h01234567);
    chk("sh24_bv",   64'(Bits_Valid_O), 64'd1);
    Shift_Valid_I = 1'b1; Shift_I = 6'd32; step(1); Shift_Valid_I = 1'b0;
    chk("sh32_bv",   64'(Bits_Valid_O), 64'd0);
    chk("sh32_bits", 64'(Bits_O), 64'd0);
    step(4);
    chk("empty_no_en", 64'(en_cnt), 64'd2);

    mem[2] = 32'hCAFEF00D; Write_Pointer_I = 11'd3;
    step(5);
    chk("one_en_cnt", 64'(en_cnt), 64'd3);
    chk("one_addr",   64'(en_addr[2]), 64'd2);
    chk("one_bits",   64'(Bits_O), 64'hCAFEF00D);
    chk("one_rp",     64'(Read_Pointer_O), 64'd3);

    // shift 16 and fetch in the same cycle; word lands behind the 16 remaining bits
    mem[3] = 32'h11223344; Write_Pointer_I = 11'd4; Shift_Valid_I = 1'b1; Shift_I = 6'd16;
    #1;
    chk("shfetch_en",   64'(Buffer_Enable_O), 64'd1);
    chk("shfetch_addr", 64'(Buffer_Address_O), 64'd3);
    step(1); Shift_Valid_I = 1'b0;
    step(2);
    chk("shfetch_bits", 64'(Bits_O), 64'hF00D1122);
    chk("shfetch_bv",   64'(Bits_Valid_O), 64'd1);
    chk("shfetch_cnt",  64'(en_cnt), 64'd4);

    Shift_Valid_I = 1'b1; Shift_I = 6'd33; step(1); Shift_Valid_I = 1'b0;
    chk("err33_bits", 64'(Bits_O), 64'hF00D1122);
    chk("err33_err",  64'(Error_O), 64'd1);
    step(2);
    chk("err_sticky", 64'(Error_O), 64'd1);
    Shift_Valid_I = 1'b1; Shift_I = 6'd16; step(1); Shift_Valid_I = 1'b0;
    chk("after_err_sh16", 64'(Bits_O), 64'h11223344);
    Shift_Valid_I = 1'b1; Shift_I = 6'd32; step(1); Shift_Valid_I = 1'b0;
    chk("drain_bv", 64'(Bits_Valid_O), 64'd0);
    Shift_Valid_I = 1'b1; Shift_I = 6'd4; step(1); Shift_Valid_I = 1'b0;
    chk("errbv_err", 64'(Error_O), 64'd1);
    chk("errbv_bv",  64'(Bits_Valid_O), 64'd0);

    Write_Pointer_I = 11'h3FF; Flush_I = 1'b1; step(1); Flush_I = 1'b0;
    chk("flush_err",  64'(Error_O), 64'd0);
    chk("flush_rp",   64'(Read_Pointer_O), 64'h3FF);
    chk("flush_bv",   64'(Bits_Valid_O), 64'd0);
    chk("flush_bits", 64'(Bits_O), 64'd0);
    step(2);
    chk("flush_no_en", 64'(en_cnt), 64'd4);

    mem[10'h3FF] = 32'hA5A5A5A5; mem[0] = 32'h5A5A5A5A; Write_Pointer_I = 11'h401;
    step(6);
    chk("wrap_cnt",   64'(en_cnt), 64'd6);
    chk("wrap_addr0", 64'(en_addr[4]), 64'h3FF);
    chk("wrap_addr1", 64'(en_addr[5]), 64'h000);
    chk("wrap_rp",    64'(Read_Pointer_O), 64'h401);
    chk("wrap_bits",  64'(Bits_O), 64'hA5A5A5A5);
    Shift_Valid_I = 1'b1; Shift_I = 6'd32; step(1);
    chk("wrap_bits2", 64'(Bits_O), 64'h5A5A5A5A);
    step(1); Shift_Valid_I = 1'b0;
    chk("wrap_drain_bv", 64'(Bits_Valid_O), 64'd0);

    // reset lands while the fetched word is on its way back
    mem[1] = 32'h12345678; Write_Pointer_I = 11'h402;
    #1;
    chk("mid_en", 64'(Buffer_Enable_O), 64'd1);
    step(1);
    #1; resetn = 1'b0; Write_Pointer_I = '0;
    #2;
    chk("mid_rst_rp",   64'(Read_Pointer_O), 64'd0);
    chk("mid_rst_bv",   64'(Bits_Valid_O), 64'd0);
    chk("mid_rst_bits", 64'(Bits_O), 64'd0);
    chk("mid_rst_en",   64'(Buffer_Enable_O), 64'd0);
    #1; resetn = 1'b1;
    step(3);
    chk("post_rst_bits", 64'(Bits_O), 64'd0);
    chk("post_rst_bv",   64'(Bits_Valid_O), 64'd0);
    chk("post_rst_cnt",  64'(en_cnt), 64'd7);
    chk("post_rst_rp",   64'(Read_Pointer_O), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
